// File: rtl/spi_mem_ctrl_pkg.sv
// spi_mem_ctrl_pkg -- request encodings, FSM states and SPI frame constants
// shared by the memory-side SPI controller. Rev 1.0
`default_nettype none

package spi_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_ctrl_op_e;

   typedef enum logic {
      PC  = 1'b0,
      MAR = 1'b1
   } addr_sel_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      HOLD  = 2'd3
   } spi_mem_state_e;

   localparam logic [7:0] SPI_CMD_READ   = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
   localparam int         SPI_FRAME_BITS = 40;

   // The reserved encoding behaves exactly like MEM_NOP.
   function automatic logic op_is_active(input mem_ctrl_op_e op);
      return (op == MEM_READ) || (op == MEM_WRITE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shifter.sv
// spi_shifter -- 40-bit MSB-first mode-0 frame shifter with SCK phase, MISO
// capture and end-of-frame flag. Rev 1.0
`default_nettype none

module spi_shifter
   import spi_mem_ctrl_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load_i,
   input  logic [SPI_FRAME_BITS-1:0] frame_i,
   input  logic                      shift_en_i,
   input  logic                      spi_miso_i,
   output logic                      spi_sck_o,
   output logic                      spi_mosi_o,
   output logic [7:0]                rx_byte_o,
   output logic                      last_bit_o
);

   logic [SPI_FRAME_BITS-1:0] sr_q;
   logic                      sck_q;
   logic [5:0]                bit_q;
   logic [7:0]                rx_q;

   // Low phase samples MISO on the edge that raises SCK; high phase advances
   // the frame so MOSI only changes at the start of a low phase.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sr_q  <= '0;
         sck_q <= 1'b0;
         bit_q <= '0;
         rx_q  <= '0;
      end else if (load_i) begin
         sr_q  <= frame_i;
         sck_q <= 1'b0;
         bit_q <= 6'(SPI_FRAME_BITS - 1);
      end else if (shift_en_i) begin
         if (!sck_q) begin
            sck_q <= 1'b1;
            rx_q  <= {rx_q[6:0], spi_miso_i};
         end else begin
            sck_q <= 1'b0;
            sr_q  <= {sr_q[SPI_FRAME_BITS-2:0], 1'b0};
            bit_q <= bit_q - 6'd1;
         end
      end
   end

   assign spi_sck_o  = sck_q;
   assign spi_mosi_o = sr_q[SPI_FRAME_BITS-1];
   assign rx_byte_o  = rx_q;
   assign last_bit_o = sck_q && (bit_q == 6'd0);

endmodule

`default_nettype wire

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl -- turns MEM_READ/MEM_WRITE requests into one SPI mode-0
// transaction on the flash (PC) or SRAM (MAR) and pulses mem_op_done. Rev 1.0
`default_nettype none

module spi_mem_ctrl
   import spi_mem_ctrl_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = 8,
   parameter int ADDR_WIDTH     = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  mem_ctrl_op_e              mem_ctrl_op,
   input  addr_sel_e                 addr_sel,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_BUS_WIDTH-1:0] data_in,
   output logic [DATA_BUS_WIDTH-1:0] data_out,
   output logic                      mem_op_done,
   output logic                      spi_sck,
   output logic                      spi_mosi,
   input  logic                      spi_miso,
   output logic                      spi_cs_flash_n,
   output logic                      spi_cs_ram_n
`ifdef SCAN
   ,
   input  logic                      test,
   input  logic                      scan_in,
   output logic                      scan_out
`endif
);

   spi_mem_state_e            state_q, state_d;
   logic                      rd_q, rd_d;
   logic                      cs_flash_n_q, cs_flash_n_d;
   logic                      cs_ram_n_q, cs_ram_n_d;
   logic                      done_q, done_d;
   logic [DATA_BUS_WIDTH-1:0] data_out_q, data_out_d;

   logic                      req;
   logic                      req_rd;
   logic                      illegal;
   logic                      load;
   logic [23:0]               addr_ext;
   logic [SPI_FRAME_BITS-1:0] frame;
   logic                      last_bit;
   logic [7:0]                rx_byte;

   assign req      = op_is_active(mem_ctrl_op);
   assign req_rd   = (mem_ctrl_op == MEM_READ);
   assign illegal  = (mem_ctrl_op == MEM_WRITE) && (addr_sel == PC);
   assign addr_ext = 24'(addr);
   assign frame    = {req_rd ? SPI_CMD_READ : SPI_CMD_WRITE, addr_ext,
                      req_rd ? 8'h00 : data_in};

   spi_shifter u_shifter (
      .clock      (clock),
      .reset      (reset),
      .load_i     (load),
      .frame_i    (frame),
      .shift_en_i (state_q == SHIFT),
      .spi_miso_i (spi_miso),
      .spi_sck_o  (spi_sck),
      .spi_mosi_o (spi_mosi),
      .rx_byte_o  (rx_byte),
      .last_bit_o (last_bit)
   );

   always_comb begin
      state_d      = state_q;
      load         = 1'b0;
      rd_d         = rd_q;
      cs_flash_n_d = cs_flash_n_q;
      cs_ram_n_d   = cs_ram_n_q;
      done_d       = 1'b0;
      data_out_d   = data_out_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               // A flash write is refused without touching the SPI pins.
               if (illegal) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d      = SHIFT;
                  load         = 1'b1;
                  rd_d         = req_rd;
                  cs_flash_n_d = (addr_sel != PC);
                  cs_ram_n_d   = (addr_sel != MAR);
               end
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_d      = DONE;
               done_d       = 1'b1;
               cs_flash_n_d = 1'b1;
               cs_ram_n_d   = 1'b1;
               if (rd_q) begin
                  data_out_d = rx_byte;
               end
            end
         end
         DONE:    state_d = req ? HOLD : IDLE;
         HOLD:    if (!req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         rd_q         <= 1'b0;
         cs_flash_n_q <= 1'b1;
         cs_ram_n_q   <= 1'b1;
         done_q       <= 1'b0;
         data_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         rd_q         <= rd_d;
         cs_flash_n_q <= cs_flash_n_d;
         cs_ram_n_q   <= cs_ram_n_d;
         done_q       <= done_d;
         data_out_q   <= data_out_d;
      end
   end

   assign data_out       = data_out_q;
   assign mem_op_done    = done_q;
   assign spi_cs_flash_n = cs_flash_n_q;
   assign spi_cs_ram_n   = cs_ram_n_q;

`ifdef SCAN
   // Flops are stitched into the chain at DFT insertion; the port stays quiet in mission mode.
   assign scan_out = test & scan_in;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl -- directed and randomized transactions for spi_mem_ctrl,
// checked against a frame/timing model built from the protocol rules. Rev 1.0
`default_nettype none

module tb_spi_mem_ctrl;
   import spi_mem_ctrl_pkg::*;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   mem_ctrl_op_e mem_ctrl_op = MEM_NOP;
   addr_sel_e    addr_sel = PC;
   logic [15:0]  addr = '0;
   logic [7:0]   data_in = '0;
   logic [7:0]   data_out;
   logic         mem_op_done;
   logic         spi_sck;
   logic         spi_mosi;
   logic         spi_miso = 1'b0;
   logic         spi_cs_flash_n;
   logic         spi_cs_ram_n;

   int           n_checks = 0;
   int           n_err = 0;
   logic [7:0]   model_dout = 8'h00;

   spi_mem_ctrl #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_ctrl_op    (mem_ctrl_op),
      .addr_sel       (addr_sel),
      .addr           (addr),
      .data_in        (data_in),
      .data_out       (data_out),
      .mem_op_done    (mem_op_done),
      .spi_sck        (spi_sck),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .spi_cs_flash_n (spi_cs_flash_n),
      .spi_cs_ram_n   (spi_cs_ram_n)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request from C0; samples every cycle #1 after the edge and plays an
   // SPI device that returns mbyte in the last 8 low phases.
   task automatic run_txn(input mem_ctrl_op_e op, input addr_sel_e sel, input logic [15:0] a,
                          input logic [7:0] din, input logic [7:0] mbyte, input bit hold);
      bit          legal, rd;
      logic [39:0] exp_frame, got_frame;
      logic [7:0]  exp_dout, dout_at_done;
      int          done_cyc, ndone, sel_low, other_low, first_low, sck_rise, low_idx;
      logic        prev_sck, last_mosi, mosi_bad;
      legal     = !(op == MEM_WRITE && sel == PC);
      rd        = (op == MEM_READ);
      exp_frame = {rd ? 8'h03 : 8'h02, 8'h00, a, rd ? 8'h00 : din};
      exp_dout  = rd ? mbyte : model_dout;
      got_frame = '0; dout_at_done = '0;
      done_cyc = 0; ndone = 0; sel_low = 0; other_low = 0; first_low = 0;
      sck_rise = 0; low_idx = 0; prev_sck = 1'b0; last_mosi = 1'b0; mosi_bad = 1'b0;

      @(negedge clock);
      mem_ctrl_op = op; addr_sel = sel; addr = a; data_in = din;
      for (int c = 1; c <= 120; c++) begin
         @(posedge clock); #1;
         if ((sel == MAR) ? !spi_cs_ram_n : !spi_cs_flash_n) sel_low++;
         if ((sel == MAR) ? !spi_cs_flash_n : !spi_cs_ram_n) other_low++;
         if ((!spi_cs_ram_n || !spi_cs_flash_n) && first_low == 0) first_low = c;
         if (spi_sck && !prev_sck) sck_rise++;
         prev_sck = spi_sck;
         if ((!spi_cs_ram_n || !spi_cs_flash_n) && !spi_sck && low_idx < 40) begin
            got_frame[39-low_idx] = spi_mosi;
            last_mosi = spi_mosi;
            spi_miso  = (low_idx >= 32) ? mbyte[39-low_idx] : 1'($urandom);
            low_idx++;
         end else if ((!spi_cs_ram_n || !spi_cs_flash_n) && spi_sck) begin
            if (spi_mosi !== last_mosi) mosi_bad = 1'b1;
         end
         if (mem_op_done) begin
            ndone++;
            if (done_cyc == 0) begin
               done_cyc     = c;
               dout_at_done = data_out;
            end
         end
         // Latched request must be ignored: scramble it once accepted.
         if (c == 1 && !hold) begin
            mem_ctrl_op = MEM_NOP;
            addr = 16'($urandom);
            data_in = 8'($urandom);
         end
         if (hold && done_cyc != 0 && c == done_cyc + 10) mem_ctrl_op = MEM_NOP;
         if (done_cyc != 0 && c >= done_cyc + (hold ? 11 : 2)) break;
      end

      chk("done_cycle", 64'(done_cyc), legal ? 64'd81 : 64'd1);
      chk("done_pulses", 64'(ndone), 64'd1);
      chk("data_out_at_done", 64'(dout_at_done), 64'(exp_dout));
      chk("cs_selected_cycles", 64'(sel_low), legal ? 64'd80 : 64'd0);
      chk("cs_other_cycles", 64'(other_low), 64'd0);
      chk("sck_rising_edges", 64'(sck_rise), legal ? 64'd40 : 64'd0);
      if (legal) begin
         chk("cs_first_low_cycle", 64'(first_low), 64'd1);
         chk("mosi_frame", 64'(got_frame), 64'(exp_frame));
         chk("mosi_stable_high_phase", 64'(mosi_bad), 64'd0);
      end
      chk("data_out_after", 64'(data_out), 64'(exp_dout));
      model_dout = exp_dout;
   endtask

   initial begin
      int          rsv_activity;
      mem_ctrl_op_e rop;
      addr_sel_e    rsel;

      repeat (3) @(posedge clock);
      #1;
      chk("reset_cs_flash_n", 64'(spi_cs_flash_n), 64'd1);
      chk("reset_cs_ram_n", 64'(spi_cs_ram_n), 64'd1);
      chk("reset_sck", 64'(spi_sck), 64'd0);
      chk("reset_mosi", 64'(spi_mosi), 64'd0);
      chk("reset_done", 64'(mem_op_done), 64'd0);
      chk("reset_data_out", 64'(data_out), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      run_txn(MEM_READ,  MAR, 16'h1234, 8'h77, 8'hA5, 1'b0);
      run_txn(MEM_READ,  PC,  16'h0007, 8'h11, 8'h3C, 1'b0);
      run_txn(MEM_WRITE, MAR, 16'h00FF, 8'h5A, 8'hE1, 1'b0);
      run_txn(MEM_WRITE, PC,  16'h4321, 8'h99, 8'h00, 1'b0);
      run_txn(MEM_READ,  MAR, 16'hBEEF, 8'h00, 8'h81, 1'b1);
      run_txn(MEM_READ,  PC,  16'h8000, 8'h00, 8'h6E, 1'b0);

      // Reserved op encoding must start nothing.
      rsv_activity = 0;
      @(negedge clock);
      mem_ctrl_op = mem_ctrl_op_e'(2'b11); addr_sel = MAR;
      for (int c = 0; c < 6; c++) begin
         @(posedge clock); #1;
         if (!spi_cs_ram_n || !spi_cs_flash_n || mem_op_done || spi_sck) rsv_activity++;
      end
      chk("reserved_op_activity", 64'(rsv_activity), 64'd0);
      @(negedge clock);
      mem_ctrl_op = MEM_NOP;
      @(negedge clock);

      // Reset asserted during C30 of a read.
      mem_ctrl_op = MEM_READ; addr_sel = MAR; addr = 16'h0042; data_in = 8'h00;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clock); #1;
         if (c == 1) mem_ctrl_op = MEM_NOP;
         spi_miso = 1'($urandom);
      end
      chk("midtxn_cs_ram_low", 64'(spi_cs_ram_n), 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("rst_cs_flash_n", 64'(spi_cs_flash_n), 64'd1);
      chk("rst_cs_ram_n", 64'(spi_cs_ram_n), 64'd1);
      chk("rst_sck", 64'(spi_sck), 64'd0);
      chk("rst_done", 64'(mem_op_done), 64'd0);
      chk("rst_data_out", 64'(data_out), 64'd0);
      model_dout = 8'h00;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run_txn(MEM_READ, MAR, 16'h0ABC, 8'h00, 8'hC7, 1'b0);

      for (int t = 0; t < 8; t++) begin
         rop  = ($urandom_range(0, 1) != 0) ? MEM_READ : MEM_WRITE;
         rsel = ($urandom_range(0, 1) != 0) ? MAR : PC;
         run_txn(rop, rsel, 16'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
